// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle for the PS/2 scancode decoder.
// The decoder side (master) produces key events and status pulses.
// The consumer side (slave) supplies receiver bytes and event_ready.
`timescale 1ns/1ps
interface ps2_scancode_decoder_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       received_data;
  logic             received_data_en;
  logic             event_ready;
  logic             event_valid;
  logic [7:0]       event_code;
  logic             event_extended;
  logic             event_released;
  logic [CNT_W-1:0] fifo_count;
  logic             ack_received;
  logic             bat_passed;
  logic             seq_error;
  logic             overflow;

  modport master (
    input  received_data, received_data_en, event_ready,
    output event_valid, event_code, event_extended, event_released,
           fifo_count, ack_received, bat_passed, seq_error, overflow
  );

  modport slave (
    output received_data, received_data_en, event_ready,
    input  event_valid, event_code, event_extended, event_released,
           fifo_count, ack_received, bat_passed, seq_error, overflow
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: folds E0/F0 prefixes and the E1 Pause sequence
// into {extended, released, code} events, queues them in a FWFT FIFO and
// reports device responses and malformed sequences as one-cycle pulses.
`timescale 1ns/1ps
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_scancode_decoder_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  // The timeout fires on the idle cycle that brings the counter to TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_e;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ack_q, ack_d, bat_q, bat_d, err_q, err_d, ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  event_t           mem_q [FIFO_DEPTH];
  event_t           push_ev, head;
  logic             push_req, push, pop, full;
  logic [7:0]       b;

  assign b = bus.received_data;

  // Sequence decoder: next state, event to push, status pulses, timeout.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    push_req = 1'b0;
    push_ev  = '0;
    ack_d    = 1'b0;
    bat_d    = 1'b0;
    err_d    = 1'b0;
    if (bus.received_data_en) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          case (b)
            8'hE0:        state_d = S_E0;
            8'hF0:        state_d = S_F0;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            8'hFA:        ack_d = 1'b1;
            8'hAA:        bat_d = 1'b1;
            8'h00, 8'hFF: err_d = 1'b1;
            8'hEE, 8'hFE: begin end
            default: begin
              push_req = 1'b1;
              push_ev  = '{extended: 1'b0, released: 1'b0, code: b};
            end
          endcase
        end
        S_E0: begin
          state_d = S_IDLE;
          if (b == 8'hF0) begin
            state_d = S_E0F0;
          end else if (b == 8'h12) begin
            // Fake shift around extended keys: swallowed.
          end else if (is_prefix(b)) begin
            err_d = 1'b1;
          end else begin
            push_req = 1'b1;
            push_ev  = '{extended: 1'b1, released: 1'b0, code: b};
          end
        end
        S_F0: begin
          state_d = S_IDLE;
          if (is_prefix(b)) begin
            err_d = 1'b1;
          end else begin
            push_req = 1'b1;
            push_ev  = '{extended: 1'b0, released: 1'b1, code: b};
          end
        end
        S_E0F0: begin
          state_d = S_IDLE;
          if (b == 8'h12) begin
            // Fake shift release: swallowed.
          end else if (is_prefix(b)) begin
            err_d = 1'b1;
          end else begin
            push_req = 1'b1;
            push_ev  = '{extended: 1'b1, released: 1'b1, code: b};
          end
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d  = S_IDLE;
            push_req = 1'b1;
            push_ev  = '{extended: 1'b1, released: 1'b0, code: 8'h77};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // FIFO bookkeeping: a pop at full frees the slot for a same-cycle push.
  always_comb begin
    pop      = (count_q != '0) && bus.event_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    push     = push_req && (!full || pop);
    ovf_d    = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q  <= S_IDLE;
      skip_q   <= '0;
      tmo_q    <= '0;
      ack_q    <= 1'b0;
      bat_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      tmo_q    <= tmo_d;
      ack_q    <= ack_d;
      bat_q    <= bat_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Event storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the head is masked to zero whenever the count is zero.
    if (push) mem_q[wr_ptr_q] <= push_ev;
  end

  // First-word-fall-through head and registered status pulses.
  always_comb begin
    head               = bus.event_valid ? mem_q[rd_ptr_q] : '0;
    bus.event_valid    = (count_q != '0);
    bus.event_code     = head.code;
    bus.event_extended = head.extended;
    bus.event_released = head.released;
    bus.fifo_count     = count_q;
    bus.ack_received   = ack_q;
    bus.bat_passed     = bat_q;
    bus.seq_error      = err_q;
    bus.overflow       = ovf_q;
  end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a table of single-sequence
// vectors plus hand-written sequences for Pause, timeout, FIFO full and reset.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_scancode_decoder_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  ps2_scancode_decoder #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic       ev, ext, rel;
    logic [7:0] code;
    int         ack, bat, err;
  } vec_t;

  vec_t vecs[$];
  int total = 0, bad = 0;
  int ack_cnt = 0, bat_cnt = 0, err_cnt = 0, ovf_cnt = 0;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.ack_received) ack_cnt++;
    if (bus.bat_passed)   bat_cnt++;
    if (bus.seq_error)    err_cnt++;
    if (bus.overflow)     ovf_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                              logic ev, logic ext, logic rel, logic [7:0] code,
                              int ack, int bat, int err);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.ev = ev; v.ext = ext; v.rel = rel; v.code = code;
    v.ack = ack; v.bat = bat; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the strobe is taken at the next rising edge.
  task automatic send_byte(input logic [7:0] v);
    bus.received_data    = v;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
    bus.received_data    = 8'h00;
  endtask

  task automatic pop_one();
    bus.event_ready = 1'b1;
    @(negedge clk);
    bus.event_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic ext, input logic rel, input logic [7:0] code);
    check({tag, "_valid"}, bus.event_valid, 1);
    check({tag, "_ext"},   bus.event_extended, ext);
    check({tag, "_rel"},   bus.event_released, rel);
    check({tag, "_code"},  bus.event_code, code);
  endtask

  initial begin
    int a0, bt0, e0, o0, first;
    logic [7:0] pause_seq [8];
    logic [7:0] order [4];

    vecs.push_back(mk(1, 8'h1C, 8'h00, 8'h00, 1, 0, 0, 8'h1C, 0, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h1C, 8'h00, 1, 0, 1, 8'h1C, 0, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h75, 8'h00, 1, 1, 0, 8'h75, 0, 0, 0));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h75, 1, 1, 1, 8'h75, 0, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h12, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'hFA, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 8'hEE, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'hFE, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'hE0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(2, 8'hE0, 8'hE1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(2, 8'hF0, 8'hF0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(2, 8'hF0, 8'hE0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'hE1, 0, 0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(2, 8'hF0, 8'h12, 8'h00, 1, 0, 1, 8'h12, 0, 0, 0));
    vecs.push_back(mk(1, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 8'h5A, 0, 0, 0));

    reset = 1'b0;
    bus.received_data = 8'h00;
    bus.received_data_en = 1'b0;
    bus.event_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_valid", bus.event_valid, 0);
    check("rst_code", bus.event_code, 0);
    check("rst_ext", bus.event_extended, 0);
    check("rst_rel", bus.event_released, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ack", bus.ack_received, 0);
    check("rst_bat", bus.bat_passed, 0);
    check("rst_err", bus.seq_error, 0);
    check("rst_ovf", bus.overflow, 0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single sequences, each starting from an empty FIFO.
    foreach (vecs[i]) begin
      a0 = ack_cnt; bt0 = bat_cnt; e0 = err_cnt;
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), bus.event_valid, vecs[i].ev);
      check($sformatf("v%0d_count", i), bus.fifo_count, vecs[i].ev ? 1 : 0);
      if (vecs[i].ev) begin
        check_head($sformatf("v%0d", i), vecs[i].ext, vecs[i].rel, vecs[i].code);
        pop_one();
      end
      check($sformatf("v%0d_ack", i), ack_cnt - a0, vecs[i].ack);
      check($sformatf("v%0d_bat", i), bat_cnt - bt0, vecs[i].bat);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].err);
      check($sformatf("v%0d_empty", i), bus.fifo_count, 0);
    end

    // Make then break of the same key; first-event latency is one cycle.
    send_byte(8'h1C);
    check("lat_valid", bus.event_valid, 1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("mb_count", bus.fifo_count, 2);
    check_head("mb_make", 0, 0, 8'h1C);
    pop_one();
    check_head("mb_break", 0, 1, 8'h1C);
    pop_one();
    check("mb_empty", bus.event_valid, 0);
    bus.event_ready = 1'b1;
    @(negedge clk);
    bus.event_ready = 1'b0;
    check("ready_empty_count", bus.fifo_count, 0);

    // Pause: eight bytes give exactly one event, then the FSM is idle again.
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    e0 = err_cnt;
    for (int i = 0; i < 7; i++) send_byte(pause_seq[i]);
    check("pause_early", bus.event_valid, 0);
    send_byte(pause_seq[7]);
    check("pause_count", bus.fifo_count, 1);
    check_head("pause", 1, 0, 8'h77);
    send_byte(8'h1C);
    @(negedge clk);
    check("pause_after_count", bus.fifo_count, 2);
    check("pause_err", err_cnt - e0, 0);
    pop_one();
    check_head("pause_after", 0, 0, 8'h1C);
    pop_one();

    // Timeout inside a sequence.
    e0 = err_cnt;
    first = -1;
    send_byte(8'hF0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.seq_error && first < 0) first = i;
    end
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_when", (first >= 15 && first <= 16) ? 1 : 0, 1);
    check("tmo_noevent", bus.event_valid, 0);
    send_byte(8'h1C);
    check_head("tmo_next", 0, 0, 8'h1C);
    pop_one();

    // A strobe on the last allowed idle cycle wins over the timeout.
    e0 = err_cnt;
    send_byte(8'hF0);
    repeat (14) @(negedge clk);
    send_byte(8'h1C);
    @(negedge clk);
    check("tmo_race_err", err_cnt - e0, 0);
    check_head("tmo_race", 0, 1, 8'h1C);
    pop_one();

    // Fill the FIFO, overflow once, then push and pop together at full.
    o0 = ovf_cnt;
    send_byte(8'h15);
    send_byte(8'h1D);
    send_byte(8'h24);
    send_byte(8'h2D);
    check("full_count", bus.fifo_count, 4);
    send_byte(8'h2C);
    @(negedge clk);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_count", bus.fifo_count, 4);
    check("ovf_head", bus.event_code, 8'h15);
    bus.event_ready = 1'b1;
    send_byte(8'h35);
    bus.event_ready = 1'b0;
    check("pp_full_count", bus.fifo_count, 4);
    @(negedge clk);
    check("pp_full_ovf", ovf_cnt - o0, 1);
    order = '{8'h1D, 8'h24, 8'h2D, 8'h35};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("order%0d", k), bus.event_code, order[k]);
      pop_one();
    end
    check("drain_count", bus.fifo_count, 0);

    // Push and ready together while empty: push only.
    bus.event_ready = 1'b1;
    send_byte(8'h43);
    bus.event_ready = 1'b0;
    check("pp_empty_count", bus.fifo_count, 1);
    check_head("pp_empty", 0, 0, 8'h43);
    pop_one();

    // Reset mid-sequence with a queued event.
    send_byte(8'h1C);
    send_byte(8'hE0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_count", bus.fifo_count, 0);
    check("midrst_valid", bus.event_valid, 0);
    check("midrst_code", bus.event_code, 0);
    reset = 1'b1;
    send_byte(8'h75);
    check_head("midrst_next", 0, 0, 8'h75);
    pop_one();
    check("final_count", bus.fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
